keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_CYCLES, default 4: clock cycles each row is driven during scanning; legal values are 3 or more.
REQ-002 Parameter DEBOUNCE_CYCLES, default 8: consecutive stable cycles required to accept a press or a release.
REQ-003 Port clk, input, 1 bit: the single system clock.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port cols_n, input, 4 bits: keypad columns, already 2-FF synchronized upstream; low means a key is closed in the driven row.
REQ-006 Port rows_n, output, 4 bits: keypad row drive, one-hot active-low.
REQ-007 Port key_code, output, 4 bits: hex code of the last accepted key.
REQ-008 Port key_valid, output, 1 bit: one-cycle pulse when a new key is accepted.
REQ-009 Port key_held, output, 1 bit: high while an accepted key is held or its release is being debounced.

Function
REQ-010 FSM states SHALL be SCAN, DEBOUNCE, HELD and RELEASE.
REQ-011 In SCAN, each row r SHALL be driven low for exactly SCAN_CYCLES cycles (rows_n = ~(1<<r)), then the scan advances to the next row, wrapping 3->0.
REQ-012 cols_n SHALL be sampled only in the final cycle of a row dwell, which absorbs the 2-cycle synchronizer latency.
REQ-013 A sampled cols_n != 4'hF in SCAN SHALL latch row r and the lowest-index low column, freeze rows_n, clear the counter, and enter DEBOUNCE.
REQ-014 In DEBOUNCE, each cycle the latched column is low SHALL increment the counter; any high cycle SHALL return to SCAN at row (r+1) mod 4 with no output change.
REQ-015 When the counter reaches DEBOUNCE_CYCLES, the FSM SHALL enter HELD, update key_code, and assert key_valid for exactly the first HELD cycle.
REQ-016 Key map, by row then columns 0..3: row0 1,2,3,A; row1 4,5,6,B; row2 7,8,9,C; row3 E,0,F,D.
REQ-017 In HELD, rows_n SHALL stay frozen, other columns SHALL be ignored (no second key, no rollover), and a high latched column SHALL enter RELEASE with the counter cleared.
REQ-018 In RELEASE, a low latched column SHALL return to HELD with no new key_valid; DEBOUNCE_CYCLES consecutive high cycles SHALL enter SCAN at row (r+1) mod 4.
REQ-019 key_code SHALL hold its value between accepts; key_held = (state is HELD or RELEASE).
REQ-020 The counter SHALL saturate and never wrap; it is sized $clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES)+1).
REQ-021 All outputs SHALL be registered.

Reset
REQ-022 Reset SHALL take effect at a clk edge and override all other activity, including a reset asserted mid-DEBOUNCE or mid-HELD.
REQ-023 Reset values SHALL be: state SCAN, row 0, counter 0, rows_n 4'b1110, key_code 4'h0, key_valid 0, key_held 0.
REQ-024 A key already held when reset is released SHALL be detected through normal scanning and debounce.

Structure
REQ-025 Package keypad_pkg SHALL hold the state enum and the 16-entry key-map constant.
REQ-026 Sub-module debounce_counter (clear, enable, saturating count, done flag) SHALL serve both DEBOUNCE and RELEASE.

Verification
REQ-027 Stable press: cols_n=4'b1101 while rows_n=4'b1011 -> DEBOUNCE latches row2/col1; key_valid pulses once after 8 low cycles; key_code=4'h8.
REQ-028 Bounce: col low 5 cycles, then high -> no key_valid, and scanning resumes on row3 (rows_n=4'b0111).
REQ-029 Hold then second key: hold "5" (row1/col1), then also press col3 -> exactly one key_valid, key_code=4'h5, rows_n stays 4'b1101.
REQ-030 Release bounce: in RELEASE, col high 4 cycles, low 2, high 8 -> returns to HELD once, no extra pulse, then SCAN at row2.
REQ-031 Reset mid-DEBOUNCE: reset asserted for 1 cycle -> next cycle rows_n=4'b1110, key_code=0, key_valid=0.
REQ-032 Wrap: with no keys pressed, rows_n sequences 1110,1101,1011,0111,1110, each held for 4 cycles.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state type, key map and
// small decode helpers used by the scanner top.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  // Indexed by {row, col}; entry 0 is row0/col0.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col}];
  endfunction

  function automatic logic [1:0] lowest_low_col(input logic [3:0] cols_n);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!cols_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

endpackage

// File: rtl/debounce_counter.sv
// Saturating up-counter with synchronous clear; done flags the cycle whose
// enabled count completes a run of DONE_AT cycles.
module debounce_counter #(
  parameter int CNT_W   = 4,
  parameter int SAT_VAL = 8,
  parameter int DONE_AT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [CNT_W-1:0] SAT  = CNT_W'(SAT_VAL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DONE_AT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != SAT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign done  = (count_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and single-key lockout.
//   state    | meaning
//   SCAN     | walk rows, sample columns on the last dwell cycle
//   DEBOUNCE | row frozen, count consecutive low cycles on latched column
//   HELD     | key accepted, waiting for latched column to go high
//   RELEASE  | count consecutive high cycles before resuming the scan
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols_n,
  output logic [3:0] rows_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       rows_n_q, rows_n_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             cnt_clear, cnt_en, cnt_done;
  logic [CNT_W-1:0] cnt;
  logic             col_low;
  logic [1:0]       row_next;

  assign col_low  = ~cols_n[col_q];
  assign row_next = row_q + 2'd1;

  // One counter times the row dwell in SCAN and the runs in DEBOUNCE/RELEASE.
  debounce_counter #(
    .CNT_W  (CNT_W),
    .SAT_VAL(CNT_MAX),
    .DONE_AT(DEBOUNCE_CYCLES)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .enable(cnt_en),
    .count (cnt),
    .done  (cnt_done)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    rows_n_d    = rows_n_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      ST_SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_clear = 1'b1;
          if (cols_n != 4'hF) begin
            col_d   = lowest_low_col(cols_n);
            state_d = ST_DEBOUNCE;
          end else begin
            row_d    = row_next;
            rows_n_d = row_drive(row_next);
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (!col_low) begin
          state_d   = ST_SCAN;
          row_d     = row_next;
          rows_n_d  = row_drive(row_next);
          cnt_clear = 1'b1;
        end else if (cnt_done) begin
          state_d     = ST_HELD;
          key_code_d  = key_lookup(row_q, col_q);
          key_valid_d = 1'b1;
          cnt_clear   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_HELD: begin
        if (!col_low) begin
          state_d   = ST_RELEASE;
          cnt_clear = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (col_low) begin
          state_d   = ST_HELD;
          cnt_clear = 1'b1;
        end else if (cnt_done) begin
          state_d   = ST_SCAN;
          row_d     = row_next;
          rows_n_d  = row_drive(row_next);
          cnt_clear = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_d   = ST_SCAN;
        cnt_clear = 1'b1;
      end
    endcase

    key_held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      rows_n_q    <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      rows_n_q    <= rows_n_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign rows_n    = rows_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated keypad behind a 2-FF synchronizer, directed
// scenarios plus random key/glitch/reset traffic, checked against a run-length model.
module tb_keypad_scanner;

  localparam int SC = 4;
  localparam int DB = 8;
  localparam int M_SCAN = 0, M_DB = 1, M_HELD = 2, M_REL = 3;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic [3:0] cols_n = 4'hF;
  logic [3:0] rows_n, key_code;
  logic       key_valid, key_held;

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .cols_n(cols_n),
    .rows_n(rows_n), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: mode, scanned row, latched column, dwell time in row, length of current run
  int         m_mode = M_SCAN, m_row = 0, m_col = 0, m_dwell = 0, m_run = 0;
  logic [3:0] m_code = 4'h0;
  logic       m_valid = 1'b0;
  bit         model_ok = 1'b0;
  string      keys = "123A456B789CE0FD";

  logic [15:0] kp = '0;
  logic [3:0]  sync1 = 4'hF, sync2 = 4'hF;
  logic [3:0]  obs_rows_n, obs_code;
  logic        obs_valid, obs_held;
  int          pulse_cnt = 0;
  logic [3:0]  seq [20];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] key_char(input int idx);
    byte ch;
    ch = keys[idx];
    if (ch >= "A") return 4'(ch - "A" + 10);
    return 4'(ch - "0");
  endfunction

  function automatic logic [3:0] keypad_raw(input logic [3:0] rows, input logic [15:0] down);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (rows[r] === 1'b0 && down[r*4+k]) c[k] = 1'b0;
    return c;
  endfunction

  task automatic model_step(input logic [3:0] c, input logic r);
    bit found;
    if (r) begin
      m_mode = M_SCAN; m_row = 0; m_col = 0; m_dwell = 0; m_run = 0;
      m_code = 4'h0; m_valid = 1'b0; model_ok = 1'b1;
      return;
    end
    m_valid = 1'b0;
    case (m_mode)
      M_SCAN: begin
        if (m_dwell == SC - 1) begin
          m_dwell = 0;
          if (c != 4'hF) begin
            found = 1'b0;
            for (int i = 0; i < 4; i++)
              if (!found && !c[i]) begin m_col = i; found = 1'b1; end
            m_run = 0;
            m_mode = M_DB;
          end else begin
            m_row = (m_row + 1) % 4;
          end
        end else begin
          m_dwell++;
        end
      end
      M_DB: begin
        if (c[m_col]) begin
          m_mode = M_SCAN; m_row = (m_row + 1) % 4; m_dwell = 0;
        end else begin
          m_run++;
          if (m_run == DB) begin
            m_mode = M_HELD; m_code = key_char(m_row * 4 + m_col); m_valid = 1'b1;
          end
        end
      end
      M_HELD: begin
        if (c[m_col]) begin m_mode = M_REL; m_run = 0; end
      end
      default: begin
        if (!c[m_col]) begin
          m_mode = M_HELD;
        end else begin
          m_run++;
          if (m_run == DB) begin
            m_mode = M_SCAN; m_row = (m_row + 1) % 4; m_dwell = 0;
          end
        end
      end
    endcase
  endtask

  task automatic step(input bit use_kp, input logic [3:0] c_direct, input logic [3:0] glitch,
                      input logic r);
    logic [3:0] c;
    logic [3:0] exp_rows;
    @(negedge clk);
    if (model_ok) begin
      exp_rows = 4'hF;
      exp_rows[m_row] = 1'b0;
      check("rows_n", rows_n, exp_rows);
      check("key_code", key_code, m_code);
      check("key_valid", {3'b000, key_valid}, {3'b000, m_valid});
      check("key_held", {3'b000, key_held}, {3'b000, (m_mode == M_HELD) || (m_mode == M_REL)});
    end
    obs_rows_n = rows_n; obs_code = key_code; obs_valid = key_valid; obs_held = key_held;
    if (key_valid === 1'b1) pulse_cnt++;
    c = (use_kp ? sync2 : c_direct) ^ glitch;
    sync2 = sync1;
    sync1 = keypad_raw(rows_n, kp);
    cols_n = c;
    reset  = r;
    model_step(c, r);
  endtask

  task automatic wait_mode(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (m_mode != target && n < budget) begin
      step(1'b1, 4'hF, 4'h0, 1'b0);
      n++;
    end
    if (m_mode != target) begin
      errors++;
      $display("FAIL %s timeout actual_mode=%0d required_mode=%0d", name, m_mode, target);
    end
  endtask

  initial begin
    int held_drops;
    int n;

    // reset and idle row walk
    step(1'b1, 4'hF, 4'h0, 1'b1);
    step(1'b1, 4'hF, 4'h0, 1'b1);
    step(1'b1, 4'hF, 4'h0, 1'b0);
    check("reset_rows_n", obs_rows_n, 4'b1110);
    check("reset_key_code", obs_code, 4'h0);
    check("reset_key_valid", {3'b000, obs_valid}, 4'h0);
    check("reset_key_held", {3'b000, obs_held}, 4'h0);
    seq[0] = obs_rows_n;
    for (int i = 1; i < 20; i++) begin
      step(1'b1, 4'hF, 4'h0, 1'b0);
      seq[i] = obs_rows_n;
    end
    check("wrap_0", seq[0], 4'b1110);
    check("wrap_3", seq[3], 4'b1110);
    check("wrap_4", seq[4], 4'b1101);
    check("wrap_7", seq[7], 4'b1101);
    check("wrap_8", seq[8], 4'b1011);
    check("wrap_12", seq[12], 4'b0111);
    check("wrap_15", seq[15], 4'b0111);
    check("wrap_16", seq[16], 4'b1110);

    // stable press of row2/col1
    kp = 16'h0200; pulse_cnt = 0;
    wait_mode(M_HELD, 120, "press8_hold");
    step(1'b1, 4'hF, 4'h0, 1'b0);
    check("press8_valid", {3'b000, obs_valid}, 4'h1);
    check("press8_code", obs_code, 4'h8);
    check("press8_rows", obs_rows_n, 4'b1011);
    for (int i = 0; i < 10; i++) step(1'b1, 4'hF, 4'h0, 1'b0);
    check("press8_pulses", 4'(pulse_cnt), 4'd1);
    kp = '0;
    wait_mode(M_SCAN, 60, "press8_release");
    step(1'b1, 4'hF, 4'h0, 1'b0);
    check("press8_resume_row3", obs_rows_n, 4'b0111);
    check("press8_held_off", {3'b000, obs_held}, 4'h0);

    // bounce: 5 low cycles in DEBOUNCE then high
    kp = 16'h0200; pulse_cnt = 0;
    wait_mode(M_DB, 120, "bounce_debounce");
    step(1'b1, 4'hF, 4'h0, 1'b0);
    check("bounce_frozen_row2", obs_rows_n, 4'b1011);
    kp = '0;
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1101, 4'h0, 1'b0);
    step(1'b0, 4'hF, 4'h0, 1'b0);
    step(1'b0, 4'hF, 4'h0, 1'b0);
    check("bounce_resume_row3", obs_rows_n, 4'b0111);
    check("bounce_no_pulse", 4'(pulse_cnt), 4'd0);
    check("bounce_held_off", {3'b000, obs_held}, 4'h0);

    // hold "5" then add col3 in the same row
    kp = 16'h0020; pulse_cnt = 0;
    wait_mode(M_HELD, 120, "hold5");
    kp = 16'h00A0;
    for (int i = 0; i < 20; i++) step(1'b1, 4'hF, 4'h0, 1'b0);
    check("hold5_pulses", 4'(pulse_cnt), 4'd1);
    check("hold5_code", obs_code, 4'h5);
    check("hold5_rows", obs_rows_n, 4'b1101);
    check("hold5_held", {3'b000, obs_held}, 4'h1);

    // release bounce: high 4, low 2, then high until scanning resumes
    kp = 16'h0020;
    for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 4'h0, 1'b0);
    pulse_cnt = 0; held_drops = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'hF, 4'h0, 1'b0);
      if (obs_held !== 1'b1) held_drops++;
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 4'b1101, 4'h0, 1'b0);
      if (obs_held !== 1'b1) held_drops++;
    end
    kp = '0;
    step(1'b0, 4'hF, 4'h0, 1'b0);
    if (obs_held !== 1'b1) held_drops++;
    check("relbounce_held_kept", 4'(held_drops), 4'd0);
    n = 0;
    while (obs_held === 1'b1 && n < 25) begin
      step(1'b0, 4'hF, 4'h0, 1'b0);
      n++;
    end
    check("relbounce_released", {3'b000, obs_held}, 4'h0);
    check("relbounce_row2", obs_rows_n, 4'b1011);
    check("relbounce_no_pulse", 4'(pulse_cnt), 4'd0);

    // reset mid-DEBOUNCE, then key already down at reset release, then reset mid-HELD
    kp = 16'h0004;
    wait_mode(M_DB, 120, "rst_debounce");
    step(1'b1, 4'hF, 4'h0, 1'b0);
    step(1'b1, 4'hF, 4'h0, 1'b0);
    step(1'b1, 4'hF, 4'h0, 1'b1);
    step(1'b1, 4'hF, 4'h0, 1'b0);
    check("rstdb_rows", obs_rows_n, 4'b1110);
    check("rstdb_code", obs_code, 4'h0);
    check("rstdb_valid", {3'b000, obs_valid}, 4'h0);
    check("rstdb_held", {3'b000, obs_held}, 4'h0);
    pulse_cnt = 0;
    wait_mode(M_HELD, 120, "rst_redetect");
    step(1'b1, 4'hF, 4'h0, 1'b0);
    check("redetect_valid", {3'b000, obs_valid}, 4'h1);
    check("redetect_code", obs_code, 4'h3);
    step(1'b1, 4'hF, 4'h0, 1'b1);
    step(1'b1, 4'hF, 4'h0, 1'b0);
    check("rstheld_held", {3'b000, obs_held}, 4'h0);
    check("rstheld_code", obs_code, 4'h0);
    check("rstheld_rows", obs_rows_n, 4'b1110);
    kp = '0;

    // random keys, glitches and occasional resets
    for (int seg = 0; seg < 80; seg++) begin
      int kind, dur;
      kind = $urandom_range(0, 3);
      if (kind == 0)      kp = '0;
      else if (kind == 3) kp = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      else                kp = 16'h1 << $urandom_range(0, 15);
      dur = $urandom_range(5, 60);
      for (int i = 0; i < dur; i++) begin
        logic [3:0] g;
        g = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
        step(1'b1, 4'hF, g, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
      end
    end
    kp = '0;
    for (int i = 0; i < 40; i++) step(1'b1, 4'hF, 4'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
